pcss_run_ctrl: RTL and testbench

Run sequencer in front of pcss_inf's AXI-stream send port. It forwards a host configuration stream of programmed length, waits a settle period, then releases one spike frame per tik and counts tik falling edges. It finishes on a tik target or when the all-ones done marker appears on the recv stream. Single owner of S_AXIS_send; the host drives separate cfg and spike streams into it.

---
 rtl/pcss_inf_pkg.sv | 20 ++
 rtl/pcss_run_ctrl_if.sv | 15 +
 rtl/pcss_tik_edge.sv | 32 +++
 rtl/pcss_run_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pcss_run_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcss_inf_pkg.sv
// Shared types and constants for the pcss_inf front-end blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pcss_inf_pkg;

    localparam int DATA_WIDTH_DFLT = 64;

    // A recv beat carrying this word tells the run controller the chip has finished.
    localparam logic [DATA_WIDTH_DFLT-1:0] DONE_MARKER = '1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CFG      = 3'd1,
        ST_CFG_WAIT = 3'd2,
        ST_SPK      = 3'd3,
        ST_TIK_WAIT = 3'd4,
        ST_DONE     = 3'd5
    } run_state_t;

endpackage

// File: rtl/pcss_run_ctrl_if.sv
// AXI-stream bundle used for the cfg, spike and send ports of the run controller.
// Latency: n/a (wires only).
// Backpressure: tready flows from slave to master.
interface pcss_run_ctrl_if #(
    parameter int DW = pcss_inf_pkg::DATA_WIDTH_DFLT
);
    logic [DW-1:0]   tdata;
    logic            tvalid;
    logic            tready;
    logic            tlast;
    logic [DW/8-1:0] tkeep;

    modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tkeep, output tready);
endinterface

// File: rtl/pcss_tik_edge.sv
// Tik falling-edge detector with a clearable, enableable edge counter.
// Latency: fall is combinational from tik vs. its one-cycle-delayed copy; cnt updates next edge.
// Backpressure: none; every enabled falling edge is counted.
module pcss_tik_edge #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tik,
    input  logic             clr,
    input  logic             en,
    output logic             fall,
    output logic [CNT_W-1:0] cnt
);
    logic tik_dly;

    assign fall = tik_dly & ~tik;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tik_dly <= 1'b0;
            cnt     <= '0;
        end else begin
            tik_dly <= tik;
            if (clr) begin
                cnt <= '0;
            end else if (en && fall) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/pcss_run_ctrl.sv
// Run sequencer owning pcss_inf S_AXIS_send: config burst, settle wait, one spike frame per tik.
// Latency: stream mux is combinational (zero cycles); state changes take effect the next edge.
// Backpressure: m_send_tready is passed straight to whichever source stream is selected.
module pcss_run_ctrl
    import pcss_inf_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
    parameter int CFG_CNT_W  = 20,
    parameter int TIK_CNT_W  = 8,
    parameter int CFG_WAIT   = 100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CFG_CNT_W-1:0]  cfg_len,
    input  logic [TIK_CNT_W-1:0]  tik_target,
    pcss_run_ctrl_if.slave        s_cfg,
    pcss_run_ctrl_if.slave        s_spk,
    pcss_run_ctrl_if.master       m_send,
    input  logic [DATA_WIDTH-1:0] recv_tdata,
    input  logic                  recv_tvalid,
    input  logic                  tik,
    output logic                  busy,
    output logic                  done,
    output logic [TIK_CNT_W-1:0]  tik_cnt,
    output logic                  frame_late
);
    localparam int WAIT_W = $clog2(CFG_WAIT + 1);

    run_state_t            state, state_d;
    logic [CFG_CNT_W-1:0]  cfg_len_q;
    logic [CFG_CNT_W-1:0]  cfg_cnt;
    logic [TIK_CNT_W-1:0]  tik_target_q;
    logic [WAIT_W-1:0]     wait_cnt;
    logic                  frame_late_q;

    logic start_ok;
    logic marker_hit;
    logic cfg_last;
    logic cfg_hs;
    logic spk_hs;
    logic wait_done;
    logic target_hit;
    logic fall;
    logic tik_clr;
    logic tik_en;

    assign busy       = (state != ST_IDLE) && (state != ST_DONE);
    assign done       = (state == ST_DONE);
    assign frame_late = frame_late_q;

    assign start_ok   = start && !abort && ((state == ST_IDLE) || (state == ST_DONE));
    assign marker_hit = recv_tvalid && (&recv_tdata) && busy;
    assign cfg_last   = (cfg_cnt == cfg_len_q - CFG_CNT_W'(1));
    assign cfg_hs     = (state == ST_CFG) && s_cfg.tvalid && m_send.tready;
    assign spk_hs     = (state == ST_SPK) && s_spk.tvalid && m_send.tready;
    assign wait_done  = (wait_cnt == WAIT_W'(CFG_WAIT - 1));
    // Compared at counter width so the +1 wraps the same way tik_cnt does.
    assign target_hit = (tik_target_q != '0) && ((tik_cnt + TIK_CNT_W'(1)) == tik_target_q);

    assign tik_clr = abort || start_ok;
    assign tik_en  = (state == ST_SPK) || (state == ST_TIK_WAIT);

    pcss_tik_edge #(
        .CNT_W (TIK_CNT_W)
    ) u_tik_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .tik   (tik),
        .clr   (tik_clr),
        .en    (tik_en),
        .fall  (fall),
        .cnt   (tik_cnt)
    );

    assign m_send.tkeep = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d       = state;
        m_send.tdata  = '0;
        m_send.tvalid = 1'b0;
        m_send.tlast  = 1'b0;
        s_cfg.tready  = 1'b0;
        s_spk.tready  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (cfg_len == '0) ? ST_CFG_WAIT : ST_CFG;
                end
            end
            ST_CFG: begin
                m_send.tdata  = s_cfg.tdata;
                m_send.tvalid = s_cfg.tvalid;
                m_send.tlast  = cfg_last;
                s_cfg.tready  = m_send.tready;
                if (cfg_hs && cfg_last) begin
                    state_d = ST_CFG_WAIT;
                end
            end
            ST_CFG_WAIT: begin
                if (wait_done) begin
                    state_d = ST_SPK;
                end
            end
            ST_SPK: begin
                m_send.tdata  = s_spk.tdata;
                m_send.tvalid = s_spk.tvalid;
                m_send.tlast  = s_spk.tlast;
                s_spk.tready  = m_send.tready;
                // Reaching the target mid-frame truncates the frame.
                if (fall && target_hit) begin
                    state_d = ST_DONE;
                end else if (spk_hs && s_spk.tlast) begin
                    state_d = ST_TIK_WAIT;
                end
            end
            ST_TIK_WAIT: begin
                if (fall) begin
                    state_d = target_hit ? ST_DONE : ST_SPK;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (marker_hit) begin
            state_d = ST_DONE;
        end
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_len_q    <= '0;
            tik_target_q <= '0;
            cfg_cnt      <= '0;
            wait_cnt     <= '0;
            frame_late_q <= 1'b0;
        end else if (abort) begin
            cfg_cnt      <= '0;
            wait_cnt     <= '0;
            frame_late_q <= 1'b0;
        end else begin
            if (start_ok) begin
                cfg_len_q    <= cfg_len;
                tik_target_q <= tik_target;
                cfg_cnt      <= '0;
                frame_late_q <= 1'b0;
            end else begin
                if (cfg_hs) begin
                    cfg_cnt <= cfg_cnt + CFG_CNT_W'(1);
                end
                if ((state == ST_SPK) && fall) begin
                    frame_late_q <= 1'b1;
                end
            end
            wait_cnt <= (state == ST_CFG_WAIT) ? wait_cnt + WAIT_W'(1) : '0;
        end
    end
endmodule

// File: tb/tb_pcss_run_ctrl.sv
// Randomized bench for pcss_run_ctrl against a run-level model of tik counting and beat order.
module tb_pcss_run_ctrl;
    import pcss_inf_pkg::*;

    localparam int DW    = 64;
    localparam int CW    = 20;
    localparam int TW    = 8;
    localparam int WAITC = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] cfg_len = '0;
    logic [TW-1:0] tik_target = '0;
    logic [DW-1:0] recv_tdata = '0;
    logic          recv_tvalid = 1'b0;
    logic          tik = 1'b0;
    logic          busy, done, frame_late;
    logic [TW-1:0] tik_cnt;

    pcss_run_ctrl_if #(.DW(DW)) cfg_if ();
    pcss_run_ctrl_if #(.DW(DW)) spk_if ();
    pcss_run_ctrl_if #(.DW(DW)) send_if ();

    pcss_run_ctrl #(
        .DATA_WIDTH (DW),
        .CFG_CNT_W  (CW),
        .TIK_CNT_W  (TW),
        .CFG_WAIT   (WAITC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .cfg_len     (cfg_len),
        .tik_target  (tik_target),
        .s_cfg       (cfg_if.slave),
        .s_spk       (spk_if.slave),
        .m_send      (send_if.master),
        .recv_tdata  (recv_tdata),
        .recv_tvalid (recv_tvalid),
        .tik         (tik),
        .busy        (busy),
        .done        (done),
        .tik_cnt     (tik_cnt),
        .frame_late  (frame_late)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_b;
    int    n_chk = 0;
    int    n_pass = 0;
    int    exp_tik;
    bit    exp_late, exp_done;
    int    target;
    bit    noise_en = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    // Every beat leaving on the send port must be the next one the host was expected to deliver.
    always @(negedge clk) begin
        if (rst_n && send_if.tvalid && send_if.tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                mon_b = exp_q.pop_front();
                chk("send_data", send_if.tdata, mon_b.d);
                chk("send_last", send_if.tlast, mon_b.l);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (noise_en) begin
                recv_tvalid = ($urandom % 2) == 1;
                recv_tdata  = {$urandom, $urandom} & ~64'd1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got stuck want finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input int len, input int tgt);
        cfg_len    = CW'(len);
        tik_target = TW'(tgt);
        start      = 1'b1;
        cyc(1);
        start    = 1'b0;
        exp_tik  = 0;
        exp_late = 1'b0;
        exp_done = 1'b0;
        target   = tgt;
    endtask

    // Spec-level tik rule: count modulo 2^TW, a tik while in the spike phase is late, target ends the run.
    task automatic pulse_tik(input bit in_spk);
        tik = 1'b1;
        cyc(1);
        tik = 1'b0;
        cyc(1);
        exp_tik = (exp_tik + 1) % 256;
        if (in_spk) exp_late = 1'b1;
        if (target != 0 && exp_tik == target) exp_done = 1'b1;
    endtask

    task automatic chk_run();
        chk("tik_cnt", tik_cnt, exp_tik);
        chk("frame_late", frame_late, exp_late);
        chk("done", done, exp_done);
        chk("busy", busy, !exp_done);
    endtask

    task automatic send_word(input bit is_spk, input logic [DW-1:0] d, input logic last, input bit stall);
        bit got = 1'b0;
        if (is_spk) begin
            spk_if.tdata = d; spk_if.tlast = last; spk_if.tvalid = 1'b1;
        end else begin
            cfg_if.tdata = d; cfg_if.tlast = last; cfg_if.tvalid = 1'b1;
        end
        for (int c = 0; c < 200 && !got; c++) begin
            send_if.tready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk);
            if (send_if.tready && (is_spk ? spk_if.tready : cfg_if.tready)) got = 1'b1;
            @(posedge clk);
            #1;
        end
        spk_if.tvalid = 1'b0;
        cfg_if.tvalid = 1'b0;
        if (!got) chk("handshake_timeout", 0, 1);
    endtask

    // Host source tlast is random: the controller must derive cfg tlast from the programmed length.
    task automatic do_cfg(input int len, input bit stall, input int nsend);
        logic [DW-1:0] w [$];
        for (int i = 0; i < len; i++) begin
            w.push_back({$urandom, $urandom});
            exp_q.push_back('{w[i], (i == len - 1)});
        end
        for (int i = 0; i < nsend; i++) send_word(1'b0, w[i], ($urandom % 2) == 1, stall);
    endtask

    task automatic send_frame(input int n, input bit stall);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = {$urandom, $urandom};
            exp_q.push_back('{d, (i == n - 1)});
            send_word(1'b1, d, i == n - 1, stall);
        end
    endtask

    task automatic measure_wait();
        int cnt = 0;
        int bad = 0;
        send_if.tready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (spk_if.tready) break;
            if (send_if.tvalid || cfg_if.tready) bad++;
            cnt++;
        end
        @(posedge clk);
        #1;
        chk("cfg_wait_len", cnt, WAITC);
        chk("cfg_wait_quiet", bad, 0);
    endtask

    initial begin
        logic [DW-1:0] w0;
        int frames;
        cfg_if.tvalid = 1'b0; cfg_if.tlast = 1'b0; cfg_if.tdata = '0; cfg_if.tkeep = '1;
        spk_if.tvalid = 1'b0; spk_if.tlast = 1'b0; spk_if.tdata = '0; spk_if.tkeep = '1;
        send_if.tready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tik_cnt", tik_cnt, 0);
        chk("rst_frame_late", frame_late, 0);
        chk("rst_tvalid", send_if.tvalid, 0);
        chk("rst_tkeep", send_if.tkeep, 8'hFF);
        chk("rst_cfg_tready", cfg_if.tready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(2);

        // Config bursts: the first is the unstalled 5-word case, the rest random length and ready.
        for (int r = 0; r < 4; r++) begin
            automatic int len = (r == 0) ? 5 : $urandom_range(0, 4);
            do_start(len, 0);
            do_cfg(len, r != 0, len);
            chk("cfg_drained", exp_q.size(), 0);
            measure_wait();
            abort = 1'b1; cyc(1); abort = 1'b0;
            chk("abort_idle", busy, 0);
        end

        // Tik-targeted runs, each started from DONE after the first, with recv noise present.
        noise_en = 1'b1;
        for (int r = 0; r < 3; r++) begin
            do_start(1, $urandom_range(1, 4));
            do_cfg(1, 1'b0, 1);
            measure_wait();
            frames = 0;
            while (!exp_done && frames < 10) begin
                send_frame($urandom_range(1, 3), 1'b1);
                pulse_tik(1'b0);
                frames++;
                chk_run();
            end
            chk("frames_forwarded", frames, target);
            chk("spk_drained", exp_q.size(), 0);
        end
        noise_en = 1'b0;
        cyc(1);
        recv_tvalid = 1'b0;

        // Tik during a stalled frame, then counter wrap with an unbounded target.
        do_start(0, 0);
        chk_run();
        measure_wait();
        w0 = {$urandom, $urandom};
        send_if.tready = 1'b0;
        spk_if.tdata = w0; spk_if.tlast = 1'b0; spk_if.tvalid = 1'b1;
        pulse_tik(1'b1);
        chk_run();
        chk("held_valid", send_if.tvalid, 1);
        chk("held_data", send_if.tdata, w0);
        for (int i = 0; i < 4; i++) begin
            logic [DW-1:0] d = (i == 0) ? w0 : {$urandom, $urandom};
            exp_q.push_back('{d, (i == 3)});
            send_word(1'b1, d, i == 3, 1'b0);
        end
        chk("late_frame_drained", exp_q.size(), 0);
        pulse_tik(1'b0);
        chk_run();
        repeat (256) pulse_tik(1'b1);
        chk_run();
        start = 1'b1; cfg_len = 3; cyc(1); start = 1'b0;
        chk("start_ignored_spk", spk_if.tready, 1);
        chk("start_ignored_cfg", cfg_if.tready, 0);

        // Done marker freezes tik_cnt and blocks the send port.
        recv_tdata = DONE_MARKER; recv_tvalid = 1'b1;
        cyc(1);
        recv_tvalid = 1'b0;
        exp_done = 1'b1;
        chk_run();
        tik = 1'b1; cyc(1); tik = 1'b0; cyc(2);
        chk("tik_frozen", tik_cnt, exp_tik);
        spk_if.tvalid = 1'b1;
        chk("done_tvalid", send_if.tvalid, 0);
        chk("done_spk_tready", spk_if.tready, 0);
        spk_if.tvalid = 1'b0;

        // Abort coinciding with the marker wins.
        do_start(0, 0);
        chk_run();
        measure_wait();
        recv_tdata = DONE_MARKER; recv_tvalid = 1'b1; abort = 1'b1;
        cyc(1);
        recv_tvalid = 1'b0; abort = 1'b0;
        chk("abort_vs_marker_busy", busy, 0);
        chk("abort_vs_marker_done", done, 0);
        chk("abort_tik_cnt", tik_cnt, 0);

        // Target reached mid-frame truncates the frame.
        do_start(0, 1);
        measure_wait();
        send_if.tready = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back('{{$urandom, $urandom}, (i == 2)});
        spk_if.tdata = exp_q[0].d; spk_if.tlast = 1'b0; spk_if.tvalid = 1'b1;
        pulse_tik(1'b1);
        chk_run();
        chk("trunc_tvalid", send_if.tvalid, 0);
        chk("trunc_unsent", exp_q.size(), 3);
        exp_q.delete();
        spk_if.tvalid = 1'b0;

        // Reset part-way through a config burst, then a fresh shorter burst.
        do_start(5, 0);
        do_cfg(5, 1'b0, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tvalid", send_if.tvalid, 0);
        chk("mid_rst_tik_cnt", tik_cnt, 0);
        chk("mid_rst_tkeep", send_if.tkeep, 8'hFF);
        chk("mid_rst_unsent", exp_q.size(), 3);
        exp_q.delete();
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        do_start(2, 0);
        do_cfg(2, 1'b1, 2);
        chk("resend_drained", exp_q.size(), 0);
        measure_wait();
        abort = 1'b1; cyc(1); abort = 1'b0;
        chk("final_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
